// File: rtl/reg_op_sequencer.sv
// rtl/reg_op_sequencer.sv - four-phase register-file instruction sequencer with result forwarding
module reg_op_sequencer #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ins_valid,
  output logic          ins_ready,
  input  logic [1:0]    ins_op,
  input  logic [1:0]    ins_rs,
  input  logic [1:0]    ins_rt,
  input  logic [1:0]    ins_rd,
  input  logic [DW-1:0] ins_imm,
  output logic [1:0]    rs,
  output logic [1:0]    rt,
  input  logic [DW-1:0] crs,
  input  logic [DW-1:0] crt,
  output logic [1:0]    rw,
  output logic [DW-1:0] dw,
  output logic          rwe,
  output logic          done,
  output logic          carry,
  output logic          zero
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t        state;

  // Fields captured at accept; rs/rt outputs double as the captured source indices.
  logic [1:0]    op_q;
  logic [1:0]    rd_q;
  logic [DW-1:0] imm_q;

  // Forwarding record of the most recently written-back instruction.
  logic [1:0]    last_rd;
  logic [DW-1:0] last_val;
  logic          last_valid;

  // Execute-stage combinational signals.
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW:0]   sum;
  logic [DW:0]   diff;
  logic [DW-1:0] ex_res;
  logic          ex_carry;
  logic          ex_zero;

  // Operand selection (forwarded or register-file) and the ALU for the captured op.
  always_comb begin
    op_a     = (last_valid && (rs == last_rd)) ? last_val : crs;
    op_b     = (last_valid && (rt == last_rd)) ? last_val : crt;
    sum      = {1'b0, op_a} + {1'b0, op_b};
    diff     = {1'b0, op_a} - {1'b0, op_b};
    ex_res   = '0;
    ex_carry = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        ex_res   = sum[DW-1:0];
        ex_carry = sum[DW];
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the borrow (A < B).
        ex_res   = diff[DW-1:0];
        ex_carry = diff[DW];
      end
      OP_AND: begin
        ex_res   = op_a & op_b;
        ex_carry = 1'b0;
      end
      OP_LDI: begin
        ex_res   = imm_q;
        ex_carry = 1'b0;
      end
      default: begin
        ex_res   = '0;
        ex_carry = 1'b0;
      end
    endcase
    ex_zero = (ex_res == '0);
  end

  // Sequencer FSM: IDLE accepts, READ lets operands settle, EXEC registers the result, WB writes back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ins_ready  <= 1'b1;
      op_q       <= OP_ADD;
      rd_q       <= '0;
      imm_q      <= '0;
      rs         <= '0;
      rt         <= '0;
      rw         <= '0;
      dw         <= '0;
      rwe        <= 1'b0;
      done       <= 1'b0;
      carry      <= 1'b0;
      zero       <= 1'b0;
      last_rd    <= '0;
      last_val   <= '0;
      last_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ins_valid) begin
            op_q      <= ins_op;
            rs        <= ins_rs;
            rt        <= ins_rt;
            rd_q      <= ins_rd;
            imm_q     <= ins_imm;
            ins_ready <= 1'b0;
            state     <= READ;
          end
        end
        READ: begin
          state <= EXEC;
        end
        EXEC: begin
          rw    <= rd_q;
          dw    <= ex_res;
          carry <= ex_carry;
          zero  <= ex_zero;
          rwe   <= 1'b1;
          done  <= 1'b1;
          state <= WB;
        end
        WB: begin
          // The register file commits on this edge, so the forwarding record becomes valid now.
          rwe        <= 1'b0;
          done       <= 1'b0;
          last_rd    <= rw;
          last_val   <= dw;
          last_valid <= 1'b1;
          ins_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
